toggle_cover_scheduler: RTL and testbench
=========================================

// Module: toggle_cover_scheduler
// PURPOSE
//  - Front end for toggle coverage of one WIDTH-bit signal group.
//  - Detects bit toggles and keeps a sticky per-bit "reported" map.
//  - Drains each first-time toggle, once, as a serialized cover event
//    (global cover index) over a valid/ready port to the coverage reporter.
//  - Replaces per-bit, per-cycle reporting: at most one event per cycle;
//    each bit is reported only once until clear.
// PARAMETERS
//  WIDTH        62     number of monitored bits (1..1024)
//  COVER_INDEX  0      global cover index of bit 0
//  COVER_TOTAL  38253  global cover-point count; COVER_INDEX+WIDTH <= COVER_TOTAL
//  IDX_W        64     width of out_index (matches longint cover index)
// PORTS
//  clock          in   1                      rising-edge clock
//  reset          in   1                      synchronous, active-high
//  enable         in   1                      sampling enable; 0 freezes detection
//  clear          in   1                      1-cycle pulse: forget reported/pending
//  signal         in   WIDTH                  monitored bits
//  out_valid      out  1                      cover event available
//  out_ready      in   1                      reporter accepts event
//  out_index      out  IDX_W                  COVER_INDEX + bit number
//  pending_count  out  $clog2(WIDTH+1)        bits toggled, not yet accepted
//  all_covered    out  1                      every bit reported
// BEHAVIOUR
//  - Reset: prev=0, prev_vld=0, pending=0, reported=0, out_valid=0,
//    out_index=0, pending_count=0, all_covered=0; state IDLE.
//  - Toggle detect, cycle with enable=1:
//    toggle = prev_vld ? (signal ^ prev) : 0; then prev<=signal, prev_vld<=1.
//    The first enabled sample after reset or clear never reports.
//  - enable=0: prev and prev_vld hold. The drain continues.
//  - Pending set at clock edge:
//    pending <= (pending | (toggle & ~reported & ~inflight)) & ~accepted.
//  - States:
//    IDLE: out_valid=0. If pending!=0, latch lowest set bit i
//          (out_index<=COVER_INDEX+i, zero-extended to IDX_W), go PRESENT.
//    PRESENT: out_valid=1; out_index stable while out_ready=0.
//          On out_valid&out_ready: clear pending[i] and set reported[i].
//          Then latch the next-lowest pending bit (excluding i) in the same
//          edge and stay PRESENT, or go IDLE if none remain.
//  - Latency: toggle sampled in cycle n -> pending at n+1 -> out_valid at n+2
//    (from IDLE).
//  - Throughput: 1 event/cycle while out_ready=1.
//  - Ordering: lowest bit first among pending. No fairness beyond that;
//    each bit is reported once, so starvation cannot occur.
//  - Re-toggle of a pending, inflight or reported bit: no effect, no dup.
//  - Simultaneous toggle of bit i and acceptance of bit i: reported wins,
//    no re-entry.
//  - clear:
//    * zeroes reported and pending, and sets prev_vld=0.
//    * An inflight event (PRESENT with out_ready=0) stays presented until
//      accepted. It is not marked reported after clear. out_valid never drops
//      without a handshake.
//    * clear and accept in the same cycle: accept completes; reported ends 0.
//    * clear outranks same-cycle toggles.
//  - pending_count = popcount(pending), registered, 1-cycle lag. Excludes
//    the inflight bit.
//  - all_covered = &reported, registered.
//  - reset mid-operation: everything returns to reset values next cycle;
//    any inflight event is dropped.
// STRUCTURE
//  - Package toggle_cov_pkg:
//    * COVER_TOTAL
//    * cover_idx_t (logic [63:0])
//    * state enum {IDLE, PRESENT}
//    * function idx_of(base, bit) returning cover_idx_t
//  - Sub-module toggle_cov_prio_enc (WIDTH): req vector -> {found, lowest
//    index}, purely combinational. Two instances: first pick, and next pick
//    with the accepted bit masked.
//  - Everything else (edge detect, bitmaps, FSM, popcount) lives in this
//    module.
// TESTING
//  1 reset, signal=0 then 0x5 -> no event on the first sample;
//    0x5->0x4 -> one event, index COVER_INDEX+0, out_valid at n+2.
//  2 signal 0 -> all-ones (WIDTH=62), out_ready=1 -> 62 events on consecutive
//    cycles, indices COVER_INDEX+0..61 ascending; then all_covered=1.
//  3 out_ready=0 for 10 cycles with bit 7 presented -> out_index holds
//    COVER_INDEX+7; toggling bits 3 and 7 meanwhile -> after accept, bit 3
//    next; bit 7 never repeats.
//  4 clear pulsed while bit 5 is inflight with out_ready=0 -> bit 5 still
//    delivered once; pending_count=0; re-toggling bit 5 after prev_vld
//    re-primes -> reported again.
//  5 enable=0 while signal toggles -> no new pending; enable=1 -> compare
//    against the held prev value, toggled bits reported.
//  6 reset asserted mid-drain (pending_count=20) -> next cycle out_valid=0,
//    pending_count=0, all_covered=0.

Source files
------------

// File: rtl/toggle_cov_pkg.sv
// Shared types and helpers for the toggle coverage scheduler.
package toggle_cov_pkg;

  localparam int unsigned COVER_TOTAL = 38253;

  typedef logic [63:0] cover_idx_t;

  typedef enum logic [0:0] {
    IDLE,
    PRESENT
  } state_t;

  function automatic cover_idx_t idx_of(input cover_idx_t base, input int unsigned bit_num);
    return base + cover_idx_t'(bit_num);
  endfunction

endpackage

// File: rtl/toggle_cov_prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational.
module toggle_cov_prio_enc #(
  parameter int unsigned WIDTH = 62,
  parameter int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IW-1:0]    index
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/toggle_cover_scheduler.sv
// Toggle coverage front end: detects first-time bit toggles and drains each one,
// once, as a serialized cover event over a valid/ready port.
module toggle_cover_scheduler #(
  parameter int unsigned WIDTH       = 62,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253,
  parameter int unsigned IDX_W       = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           signal,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] pending_count,
  output logic                       all_covered
);

  import toggle_cov_pkg::*;

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_err
    $error("COVER_INDEX + WIDTH exceeds COVER_TOTAL");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] reported_q, reported_d;
  logic [IW-1:0]    cur_q, cur_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic             stale_q, stale_d;
  logic [CW-1:0]    pending_count_q, pending_count_d;
  logic             all_covered_q;

  logic [WIDTH-1:0] toggle, inflight, accepted, next_req;
  logic             accept;
  logic             first_found, next_found;
  logic [IW-1:0]    first_idx, next_idx;

  assign accept = (state_q == PRESENT) && out_ready;
  assign toggle = (enable && prev_vld_q) ? (signal ^ prev_q) : '0;

  always_comb begin
    inflight = '0;
    accepted = '0;
    if (state_q == PRESENT) begin
      inflight[cur_q] = 1'b1;
      if (out_ready) accepted[cur_q] = 1'b1;
    end
  end

  assign next_req = pending_q & ~inflight;

  toggle_cov_prio_enc #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_first_pick (
    .req   (pending_q),
    .found (first_found),
    .index (first_idx)
  );

  toggle_cov_prio_enc #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_next_pick (
    .req   (next_req),
    .found (next_found),
    .index (next_idx)
  );

  // An event presented across a clear belongs to the old epoch: deliver it,
  // but do not let it mark the bit reported.
  always_comb begin
    pending_d  = clear ? '0 : ((pending_q | (toggle & ~reported_q & ~inflight)) & ~accepted);
    reported_d = clear ? '0 : (reported_q | (stale_q ? '0 : accepted));
    stale_d    = stale_q;
    if (accept) begin
      stale_d = 1'b0;
    end else if (clear && (state_q == PRESENT)) begin
      stale_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    out_index_d = out_index_q;
    unique case (state_q)
      IDLE: begin
        if (!clear && first_found) begin
          state_d     = PRESENT;
          cur_d       = first_idx;
          out_index_d = IDX_W'(idx_of(cover_idx_t'(COVER_INDEX), 32'(first_idx)));
        end
      end
      PRESENT: begin
        if (accept) begin
          if (!clear && next_found) begin
            cur_d       = next_idx;
            out_index_d = IDX_W'(idx_of(cover_idx_t'(COVER_INDEX), 32'(next_idx)));
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_count_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pending_count_d = pending_count_d + CW'(next_req[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      prev_q          <= '0;
      prev_vld_q      <= 1'b0;
      pending_q       <= '0;
      reported_q      <= '0;
      cur_q           <= '0;
      out_index_q     <= '0;
      stale_q         <= 1'b0;
      pending_count_q <= '0;
      all_covered_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      if (enable) prev_q <= signal;
      prev_vld_q      <= clear ? 1'b0 : (enable | prev_vld_q);
      pending_q       <= pending_d;
      reported_q      <= reported_d;
      cur_q           <= cur_d;
      out_index_q     <= out_index_d;
      stale_q         <= stale_d;
      pending_count_q <= pending_count_d;
      all_covered_q   <= &reported_q;
    end
  end

  assign out_valid     = (state_q == PRESENT);
  assign out_index     = out_index_q;
  assign pending_count = pending_count_q;
  assign all_covered   = all_covered_q;

endmodule

// File: tb/tb_toggle_cover_scheduler.sv
// Self-checking bench for toggle_cover_scheduler: vector table plus directed sequences.
module tb_toggle_cover_scheduler;

  localparam int unsigned W  = 62;
  localparam int unsigned CI = 1000;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          clear;
  logic [W-1:0]  sig;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [5:0]    pending_count;
  logic          all_covered;

  int checks   = 0;
  int failures = 0;

  toggle_cover_scheduler #(
    .WIDTH       (W),
    .COVER_INDEX (CI),
    .COVER_TOTAL (38253),
    .IDX_W       (64)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .signal        (sig),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_index     (out_index),
    .pending_count (pending_count),
    .all_covered   (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         en;
    logic [W-1:0] sig;
    logic         rdy;
    logic         v;
    logic [63:0]  idx;
    int           cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic en, input logic [W-1:0] s, input logic rdy,
                              input logic v, input logic [63:0] idx, input int cnt);
    vec_t r;
    r.en = en; r.sig = s; r.rdy = rdy; r.v = v; r.idx = idx; r.cnt = cnt;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; clear = 1'b0; sig = '0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    chk(name, 64'(out_valid), 64'd1);
  endtask

  initial begin
    logic seen;
    logic [W-1:0] ones21;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_index", out_index, 64'd0);
    chk("rst_count", 64'(pending_count), 64'd0);
    chk("rst_allcov", 64'(all_covered), 64'd0);

    // First-sample suppression, latency, stall, enable hold, no-duplicate
    vq.push_back(mk(1'b0, 62'h0,  1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h5,  1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h4,  1'b0, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h4,  1'b0, 1'b1, 64'(CI),    1));
    vq.push_back(mk(1'b1, 62'h4,  1'b0, 1'b1, 64'(CI),    0));
    vq.push_back(mk(1'b1, 62'h4,  1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h4,  1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b0, 62'h34, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b0, 62'h34, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h34, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h34, 1'b1, 1'b1, 64'(CI+4),  2));
    vq.push_back(mk(1'b1, 62'h34, 1'b1, 1'b1, 64'(CI+5),  1));
    vq.push_back(mk(1'b1, 62'h34, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h34, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h35, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h35, 1'b1, 1'b0, 64'd0,      0));
    vq.push_back(mk(1'b1, 62'h35, 1'b1, 1'b0, 64'd0,      0));
    for (int k = 0; k < vq.size(); k++) begin
      enable = vq[k].en; sig = vq[k].sig; out_ready = vq[k].rdy;
      tick();
      chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'(vq[k].v));
      if (vq[k].v) chk($sformatf("vec%0d_index", k), out_index, vq[k].idx);
      chk($sformatf("vec%0d_count", k), 64'(pending_count), 64'(vq[k].cnt));
    end

    // All bits toggle at once: 62 back-to-back ascending events
    do_reset();
    enable = 1'b1; out_ready = 1'b1; sig = '0;
    tick();
    sig = '1;
    tick();
    for (int k = 0; k <= 62; k++) begin
      tick();
      if (k < 62) begin
        chk($sformatf("burst%0d_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("burst%0d_index", k), out_index, 64'(CI + k));
      end else begin
        chk("burst_end_valid", 64'(out_valid), 64'd0);
      end
      if (k == 0) begin
        chk("burst_count", 64'(pending_count), 64'd62);
        chk("burst_allcov_early", 64'(all_covered), 64'd0);
      end
    end
    tick();
    tick();
    chk("burst_allcov", 64'(all_covered), 64'd1);

    // Stalled bit 7; bits 3 and 7 toggle during the stall
    do_reset();
    enable = 1'b1; out_ready = 1'b0; sig = '0;
    tick();
    sig = 62'h80;
    tick();
    wait_valid("stall_wait7", 5);
    chk("stall_index7", out_index, 64'(CI + 7));
    sig = 62'h08;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_index", k), out_index, 64'(CI + 7));
    end
    chk("stall_count", 64'(pending_count), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("stall_next_valid", 64'(out_valid), 64'd1);
    chk("stall_next_index", out_index, 64'(CI + 3));
    tick();
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("stall_no_repeat", 64'(seen | out_valid), 64'd0);

    // Clear while bit 5 is inflight
    do_reset();
    enable = 1'b1; out_ready = 1'b0; sig = '0;
    tick();
    sig = 62'h20;
    tick();
    wait_valid("clr_wait5", 5);
    chk("clr_index5", out_index, 64'(CI + 5));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_hold_valid", 64'(out_valid), 64'd1);
    chk("clr_hold_index", out_index, 64'(CI + 5));
    tick();
    chk("clr_count", 64'(pending_count), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("clr_accepted", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    sig = '0;
    tick();
    wait_valid("clr_rewait5", 5);
    chk("clr_reindex5", out_index, 64'(CI + 5));
    out_ready = 1'b1;
    tick();
    chk("clr_reaccepted", 64'(out_valid), 64'd0);
    chk("clr_allcov", 64'(all_covered), 64'd0);

    // Reset in the middle of a drain
    do_reset();
    enable = 1'b1; out_ready = 1'b0; sig = '0;
    tick();
    ones21 = '0;
    for (int i = 0; i < 21; i++) ones21[i] = 1'b1;
    sig = ones21;
    tick();
    tick();
    tick();
    chk("mid_count", 64'(pending_count), 64'd20);
    chk("mid_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(pending_count), 64'd0);
    chk("mid_rst_allcov", 64'(all_covered), 64'd0);
    chk("mid_rst_index", out_index, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
